// File: rtl/pong_pkg.sv
// Shared types and defaults for the pong design's input-domain logic.
// The channel state encoding is fixed because other blocks decode it.
package pong_pkg;

    localparam int unsigned NumBtn                = 4;
    localparam int unsigned DebounceCyclesDefault = 250000;  // 5 ms at 50 MHz

    typedef enum logic [1:0] {
        StStableLow  = 2'd0,
        StCheckHigh  = 2'd1,
        StStableHigh = 2'd2,
        StCheckLow   = 2'd3
    } chan_state_e;

endpackage

// File: rtl/button_debounce_if.sv
// Button bundle between the raw pins, the debouncer and its consumers.
// The slave modport is the debouncer side.
interface button_debounce_if #(
    parameter int unsigned NUM_BTN = pong_pkg::NumBtn
) ();

    logic [NUM_BTN-1:0] buttons_raw;
    logic [NUM_BTN-1:0] buttons_db;
    logic [NUM_BTN-1:0] buttons_press;

    modport master (
        output buttons_raw,
        input  buttons_db,
        input  buttons_press
    );

    modport slave (
        input  buttons_raw,
        output buttons_db,
        output buttons_press
    );

endinterface

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, four-state debounce FSM with a
// saturating stability counter, registered level and press strobe.
module debounce_channel
    import pong_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault
) (
    input  logic clk_in,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_db,
    output logic btn_press
);

    localparam int unsigned      CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    chan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             db_q, db_d;
    logic             press_q, press_d;

    // Saturating increment; the FSM leaves CHECK at CntMax so it never wraps.
    assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        db_d    = db_q;
        press_d = 1'b0;
        unique case (state_q)
            StStableLow: begin
                if (sync2_q) begin
                    state_d = StCheckHigh;
                    cnt_d   = '0;
                end
            end
            StCheckHigh: begin
                if (!sync2_q) begin
                    state_d = StStableLow;
                    cnt_d   = '0;
                end else if (cnt_q == CntMax) begin
                    state_d = StStableHigh;
                    cnt_d   = '0;
                    db_d    = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StStableHigh: begin
                if (!sync2_q) begin
                    state_d = StCheckLow;
                    cnt_d   = '0;
                end
            end
            StCheckLow: begin
                if (sync2_q) begin
                    state_d = StStableHigh;
                    cnt_d   = '0;
                end else if (cnt_q == CntMax) begin
                    state_d = StStableLow;
                    cnt_d   = '0;
                    db_d    = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = StStableLow;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= StStableLow;
            cnt_q   <= '0;
            db_q    <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            press_q <= press_d;
        end
    end

    assign btn_db    = db_q;
    assign btn_press = press_q;

endmodule

// File: rtl/button_debounce.sv
// Debounces NUM_BTN raw push-buttons in the clk_in domain; the level outputs
// are registered so they can feed the downstream clock-domain synchroniser.
module button_debounce
    import pong_pkg::*;
#(
    parameter int unsigned NUM_BTN         = NumBtn,
    parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault
) (
    input logic              clk_in,
    input logic              rst,
    button_debounce_if.slave bus
);

    logic [NUM_BTN-1:0] db;
    logic [NUM_BTN-1:0] press;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk_in   (clk_in),
            .rst      (rst),
            .btn_raw  (bus.buttons_raw[i]),
            .btn_db   (db[i]),
            .btn_press(press[i])
        );
    end

    assign bus.buttons_db    = db;
    assign bus.buttons_press = press;

endmodule
